hazard_ctrl_unit: RTL and testbench

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_ctrl_unit.sv | 112 +++++++++++
 tb/tb_hazard_ctrl_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use / memory-busy / flush hazard controller with stall statistics
module hazard_ctrl_unit #(
  parameter int AW        = 5,
  parameter int LU_CYCLES = 1,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] if_id_rs1,
  input  logic [AW-1:0] if_id_rs2,
  input  logic          if_id_rs1_used,
  input  logic          if_id_rs2_used,
  input  logic [AW-1:0] id_ex_rd,
  input  logic          id_ex_mem_read,
  input  logic          mem_busy,
  input  logic          flush,
  input  logic          clr_stats,
  output logic          stall,
  output logic          pc_en,
  output logic          if_id_en,
  output logic          id_ex_bubble,
  output logic [CW-1:0] stall_cycles
);

  typedef enum logic {
    RUN     = 1'b0,
    LU_WAIT = 1'b1
  } state_e;

  localparam logic [3:0]    LU_INIT  = 4'(LU_CYCLES - 1);
  localparam logic [CW-1:0] STAT_MAX = '1;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [CW-1:0] stall_cnt_q;
  logic [CW-1:0] stall_cnt_d;
  logic          hz;

  // Load in EX writing a register that ID actually reads; x0 never hazards
  always_comb begin
    hz = id_ex_mem_read && (id_ex_rd != '0) &&
         ((if_id_rs1_used && (if_id_rs1 == id_ex_rd)) ||
          (if_id_rs2_used && (if_id_rs2 == id_ex_rd)));
  end

  // Stall is combinational so the first load-use bubble has zero latency
  always_comb begin
    stall        = mem_busy ||
                   ((state_q == LU_WAIT) && !flush) ||
                   ((state_q == RUN) && hz && !flush);
    pc_en        = !stall;
    if_id_en     = !stall;
    id_ex_bubble = stall && !mem_busy;
  end

  // Load-use wait FSM: memory busy freezes it, flush aborts any pending wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else if (mem_busy) begin
      state_q <= state_q;
      cnt_q   <= cnt_q;
    end else if (flush) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (hz && (LU_CYCLES > 1)) begin
            state_q <= LU_WAIT;
            cnt_q   <= LU_INIT;
          end
        end
        LU_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // Saturating stall counter; clear wins over a same-cycle increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != STAT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Statistics register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit in three configurations
module tb_hazard_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, busy, fl, clr;

  logic [2:0]  st, pc, ie, bb;
  logic [15:0] sca, scb;
  logic [3:0]  scc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          d;
    logic        stall;
    logic        bub;
    logic        pc;
    logic        ie;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];

  int lu[3]   = '{1, 3, 3};
  int smax[3] = '{65535, 65535, 15};
  int wl[3];
  int stats[3];
  int b_stalls;

  hazard_ctrl_unit #(.AW(5), .LU_CYCLES(1), .CW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_rs1_used(u1), .if_id_rs2_used(u2), .id_ex_rd(rd), .id_ex_mem_read(mr),
    .mem_busy(busy), .flush(fl), .clr_stats(clr),
    .stall(st[0]), .pc_en(pc[0]), .if_id_en(ie[0]), .id_ex_bubble(bb[0]), .stall_cycles(sca)
  );

  hazard_ctrl_unit #(.AW(5), .LU_CYCLES(3), .CW(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_rs1_used(u1), .if_id_rs2_used(u2), .id_ex_rd(rd), .id_ex_mem_read(mr),
    .mem_busy(busy), .flush(fl), .clr_stats(clr),
    .stall(st[1]), .pc_en(pc[1]), .if_id_en(ie[1]), .id_ex_bubble(bb[1]), .stall_cycles(scb)
  );

  hazard_ctrl_unit #(.AW(5), .LU_CYCLES(3), .CW(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_rs1_used(u1), .if_id_rs2_used(u2), .id_ex_rd(rd), .id_ex_mem_read(mr),
    .mem_busy(busy), .flush(fl), .clr_stats(clr),
    .stall(st[2]), .pc_en(pc[2]), .if_id_en(ie[2]), .id_ex_bubble(bb[2]), .stall_cycles(scc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sc_of(input int d);
    case (d)
      0:       return sca;
      1:       return scb;
      default: return {12'b0, scc};
    endcase
  endfunction

  // Pop every expectation pushed for this cycle and compare mid-cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("d%0d stall", e.d), 32'(st[e.d]), 32'(e.stall));
      check($sformatf("d%0d bubble", e.d), 32'(bb[e.d]), 32'(e.bub));
      check($sformatf("d%0d pc_en", e.d), 32'(pc[e.d]), 32'(e.pc));
      check($sformatf("d%0d if_id_en", e.d), 32'(ie[e.d]), 32'(e.ie));
      check($sformatf("d%0d stall_cycles", e.d), 32'(sc_of(e.d)), 32'(e.sc));
    end
  end

  function automatic logic model_hz();
    return mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction

  function automatic logic model_stall(input int d);
    return busy || ((wl[d] > 0) && !fl) || ((wl[d] == 0) && model_hz() && !fl);
  endfunction

  // One clock: drive at posedge+1, push expectations, advance model at the edge
  task automatic step(input logic [4:0] i_rs1, input logic i_u1, input logic [4:0] i_rs2,
                      input logic i_u2, input logic [4:0] i_rd, input logic i_mr,
                      input logic i_busy, input logic i_fl, input logic i_clr);
    logic s[3];
    logic h;
    rs1 = i_rs1; u1 = i_u1; rs2 = i_rs2; u2 = i_u2; rd = i_rd; mr = i_mr;
    busy = i_busy; fl = i_fl; clr = i_clr;
    h = model_hz();
    for (int d = 0; d < 3; d++) begin
      exp_t e;
      s[d]    = model_stall(d);
      e.d     = d;
      e.stall = s[d];
      e.bub   = s[d] && !busy;
      e.pc    = !s[d];
      e.ie    = !s[d];
      e.sc    = 16'(stats[d]);
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (st[1]) b_stalls++;
    for (int d = 0; d < 3; d++) begin
      if (!busy) begin
        if (fl) wl[d] = 0;
        else if (wl[d] == 0) begin
          if (h && lu[d] > 1) wl[d] = lu[d] - 1;
        end else wl[d] = wl[d] - 1;
      end
      if (clr) stats[d] = 0;
      else if (s[d] && stats[d] < smax[d]) stats[d] = stats[d] + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_use();
    step(5'd5, 1, 5'd9, 1, 5'd5, 1, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; busy = 0; fl = 0; clr = 0;
    for (int d = 0; d < 3; d++) begin wl[d] = 0; stats[d] = 0; end
    b_stalls = 0;

    #3;
    check("rst stall a", 32'(st[0]), 32'd0);
    check("rst stall c", 32'(st[2]), 32'd0);
    check("rst pc_en b", 32'(pc[1]), 32'd1);
    check("rst stats a", 32'(sca), 32'd0);
    check("rst stats c", 32'(scc), 32'd0);
    rs1 = 5'd5; u1 = 1; rd = 5'd5; mr = 1;
    #1;
    check("rst hz stall a", 32'(st[0]), 32'd1);
    check("rst hz bubble b", 32'(bb[1]), 32'd1);
    mr = 0; busy = 1;
    #1;
    check("rst busy bubble a", 32'(bb[0]), 32'd0);
    check("rst busy stall c", 32'(st[2]), 32'd1);
    busy = 0; u1 = 0; rs1 = 0; rd = 0;
    @(posedge clk); #1;
    check("rst stats held", 32'(sca), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic load-use, one and three bubbles
    load_use();
    idle(4);

    // x0 destination and unused rs2 must not hazard
    step(5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0);
    step(5'd3, 0, 5'd7, 0, 5'd7, 1, 0, 0, 0);
    step(5'd3, 0, 5'd7, 1, 5'd7, 1, 0, 0, 0);
    idle(3);

    // Memory busy during a load-use wait stretches the stall to five cycles
    b_stalls = 0;
    load_use();
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(4);
    check("b busy stretch total", 32'(b_stalls), 32'd5);

    // Flush on the second stall cycle aborts the wait
    b_stalls = 0;
    load_use();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    check("b flush abort total", 32'(b_stalls), 32'd1);

    // Flush with a same-cycle hazard: hazard ignored
    step(5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 1, 0);
    idle(2);

    // Saturation of the narrow counter, then clear while stalled
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("c saturated", 32'(scc), 32'd15);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("c cleared", 32'(scc), 32'd0);
    check("a cleared", 32'(sca), 32'd0);
    idle(2);

    // Randomised traffic on a small register space
    for (int i = 0; i < 300; i++) begin
      step(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 31) == 0));
    end
    idle(4);

    // Asynchronous reset pulse in the middle of a load-use wait
    load_use();
    rs1 = 0; u1 = 0; rs2 = 0; u2 = 0; rd = 0; mr = 0; busy = 0; fl = 0; clr = 0;
    #3;
    check("b in wait stall", 32'(st[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst stall b", 32'(st[1]), 32'd0);
    check("async rst stall c", 32'(st[2]), 32'd0);
    check("async rst stats b", 32'(scb), 32'd0);
    check("async rst stats c", 32'(scc), 32'd0);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin wl[d] = 0; stats[d] = 0; end
    @(posedge clk); #1;
    idle(3);
    load_use();
    idle(4);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
